// File: rtl/gate_array_deglitch.sv
// gate_array_deglitch: CHANNELS independent INPUTS-wide gates with a shared,
// run-time selectable function (OR/NOR/AND/NAND). Each gate result passes
// through a per-channel stability filter, so y[c] only moves once the new
// result has persisted for FILTER_CYCLES consecutive enabled clocks.
module gate_array_deglitch #(
  parameter int CHANNELS      = 3,
  parameter int INPUTS        = 3,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y_raw,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          chg
);

  // The counter never exceeds FILTER_CYCLES-1, so clog2 bits suffice; keep at
  // least one bit so FILTER_CYCLES=1 still has a legal (always-zero) counter.
  localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS*INPUTS-1:0]      a_q;
  logic [1:0]                      mode_q;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt;

  // Single input register stage; loads every edge regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      mode_q <= 2'b00;
    end else begin
      a_q    <= a;
      mode_q <= mode;
    end
  end

  // Unfiltered gate per channel: mode_q[1] picks AND over OR, mode_q[0] inverts.
  always_comb begin
    y_raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      y_raw[c] = (mode_q[1] ? (&a_q[c*INPUTS +: INPUTS]) : (|a_q[c*INPUTS +: INPUTS])) ^ mode_q[0];
    end
  end

  // Stability filter: count consecutive cycles of disagreement, commit on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      chg <= '0;
      cnt <= '0;
    end else if (!en) begin
      chg <= '0;
      cnt <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (y_raw[c] == y[c]) begin
          cnt[c] <= '0;
          chg[c] <= 1'b0;
        end else if (cnt[c] == CNT_LAST) begin
          y[c]   <= y_raw[c];
          cnt[c] <= '0;
          chg[c] <= 1'b1;
        end else begin
          cnt[c] <= cnt[c] + CNT_W'(1);
          chg[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_array_deglitch.sv
// tb_gate_array_deglitch: scoreboard bench for gate_array_deglitch. The
// stimulus process updates a behavioural model and queues the expected
// outputs for each cycle; the monitor pops and compares after every edge.
module tb_gate_array_deglitch;

  localparam int CHANNELS      = 3;
  localparam int INPUTS        = 3;
  localparam int FILTER_CYCLES = 4;
  localparam int AW            = CHANNELS * INPUTS;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [1:0]          mode;
  logic [AW-1:0]       a;
  logic [CHANNELS-1:0] y_raw;
  logic [CHANNELS-1:0] y;
  logic [CHANNELS-1:0] chg;

  gate_array_deglitch #(
    .CHANNELS      (CHANNELS),
    .INPUTS        (INPUTS),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .a     (a),
    .y_raw (y_raw),
    .y     (y),
    .chg   (chg)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHANNELS-1:0] y;
    logic [CHANNELS-1:0] y_raw;
    logic [CHANNELS-1:0] chg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: registered inputs, filtered output, and per-channel history
  // of gate results seen at enabled edges since the last commit.
  logic [AW-1:0]       m_a    = '0;
  logic [1:0]          m_mode = 2'b00;
  logic [CHANNELS-1:0] m_y    = '0;
  bit                  hist [CHANNELS][$];

  // Gate function from the truth rules: count the ones in the channel.
  function automatic logic [CHANNELS-1:0] ref_vec(input logic [1:0] md, input logic [AW-1:0] av);
    logic [CHANNELS-1:0] r;
    int ones;
    logic g;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ones = 0;
      for (int i = 0; i < INPUTS; i++) if (av[c*INPUTS + i]) ones++;
      g = md[1] ? (ones == INPUTS) : (ones > 0);
      r[c] = md[0] ? !g : g;
    end
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] md, input logic [AW-1:0] av);
    exp_t                ex;
    logic [CHANNELS-1:0] raw_seen;
    logic [CHANNELS-1:0] chg_m;
    bit                  all_differ;
    @(negedge clk);
    rst_n = r;
    en    = e;
    mode  = md;
    a     = av;
    chg_m = '0;
    if (!r) begin
      m_a    = '0;
      m_mode = 2'b00;
      m_y    = '0;
      for (int c = 0; c < CHANNELS; c++) hist[c].delete();
    end else begin
      raw_seen = ref_vec(m_mode, m_a);
      for (int c = 0; c < CHANNELS; c++) begin
        if (!e) begin
          hist[c].delete();
        end else begin
          hist[c].push_back(raw_seen[c]);
          if (hist[c].size() > FILTER_CYCLES) void'(hist[c].pop_front());
          all_differ = (hist[c].size() == FILTER_CYCLES);
          for (int k = 0; k < hist[c].size(); k++)
            if (hist[c][k] == m_y[c]) all_differ = 1'b0;
          if (all_differ) begin
            m_y[c]   = raw_seen[c];
            chg_m[c] = 1'b1;
            hist[c].delete();
          end
        end
      end
      m_a    = av;
      m_mode = md;
    end
    ex.y     = m_y;
    ex.y_raw = ref_vec(m_mode, m_a);
    ex.chg   = chg_m;
    exp_q.push_back(ex);
  endtask

  // Compare every output against one scoreboard entry.
  task automatic checkOutput(input exp_t ex);
    checks++;
    if (y !== ex.y) begin
      errors++;
      $display("[TB] FAIL y at %0t: got %b expected %b", $time, y, ex.y);
    end
    checks++;
    if (y_raw !== ex.y_raw) begin
      errors++;
      $display("[TB] FAIL y_raw at %0t: got %b expected %b", $time, y_raw, ex.y_raw);
    end
    checks++;
    if (chg !== ex.chg) begin
      errors++;
      $display("[TB] FAIL chg at %0t: got %b expected %b", $time, chg, ex.chg);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty at %0t: got no entry expected one", $time);
      end else begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized held patterns.
  initial begin
    logic [1:0]    md;
    logic [AW-1:0] av;
    int            hold;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    a     = '0;

    repeat (2) applyStimulus(1'b0, 1'b0, 2'b00, '0);
    $display("[TB] idle after reset");
    repeat (6) applyStimulus(1'b1, 1'b1, 2'b00, '0);

    $display("[TB] OR with one input high per channel");
    repeat (8) applyStimulus(1'b1, 1'b1, 2'b00, 9'b100_010_001);

    $display("[TB] two-cycle glitch on channel 1");
    repeat (2) applyStimulus(1'b1, 1'b1, 2'b00, 9'b100_000_001);
    repeat (5) applyStimulus(1'b1, 1'b1, 2'b00, 9'b100_010_001);

    $display("[TB] mode changes with all inputs high");
    repeat (6) applyStimulus(1'b1, 1'b1, 2'b00, '1);
    repeat (6) applyStimulus(1'b1, 1'b1, 2'b10, '1);
    repeat (7) applyStimulus(1'b1, 1'b1, 2'b11, '1);

    $display("[TB] reset in the middle of a filter run");
    repeat (4) applyStimulus(1'b1, 1'b1, 2'b00, '1);
    applyStimulus(1'b0, 1'b1, 2'b00, '1);
    repeat (7) applyStimulus(1'b1, 1'b1, 2'b00, '1);

    $display("[TB] enable low while inputs toggle");
    for (int i = 0; i < 10; i++) begin
      md = 2'($urandom_range(0, 3));
      av = AW'($urandom);
      applyStimulus(1'b1, 1'b0, md, av);
    end
    applyStimulus(1'b1, 1'b0, 2'b00, '0);
    repeat (6) applyStimulus(1'b1, 1'b1, 2'b00, '0);

    $display("[TB] randomized held patterns");
    for (int i = 0; i < 60; i++) begin
      md   = 2'($urandom_range(0, 3));
      av   = AW'($urandom);
      hold = int'($urandom_range(1, 7));
      for (int h = 0; h < hold; h++)
        applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, md, av);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
